// File: rtl/hack_uart.sv
// Memory-mapped 8N1 UART for two Hack I/O slots: TX slot reports busy, RX slot
// holds the last received byte with bit 15 set when empty.
module hack_uart #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load_tx,
  input  logic        load_rx,
  input  logic        rx,
  output logic        tx,
  output logic [15:0] out_tx,
  output logic [15:0] out_rx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [15:0]      out_rx_q, out_rx_d;
  logic             rx_s1_q, rx_s2_q;

  logic             in_unused;
  assign in_unused = ^in[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      out_rx_q   <= 16'h8000;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      out_rx_q   <= out_rx_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
    end
  end

  // Transmitter: load_tx is only honoured in IDLE, so strobes while busy vanish.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (tx_state_q != TX_IDLE) begin
      tx_cnt_d = (tx_cnt_q == BIT_LAST) ? '0 : tx_cnt_q + 1'b1;
    end
    case (tx_state_q)
      TX_IDLE: begin
        if (load_tx) begin
          tx_shift_d = in[7:0];
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (tx_state_q)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = tx_shift_q[0];
      default:  tx = 1'b1;
    endcase
  end

  assign out_tx = {(tx_state_q != TX_IDLE), 15'b0};

  // Receiver: an acknowledge is applied first so a completing byte on the same edge wins.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    out_rx_d   = out_rx_q;
    if (load_rx) out_rx_d = 16'h8000;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            out_rx_d   = {8'h00, rx_shift_q};
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign out_rx = out_rx_q;

endmodule

// File: tb/tb_hack_uart.sv
// Directed self-checking bench for hack_uart at 4 clocks per bit.
module tb_hack_uart;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_w = '0;
  logic        load_tx = 1'b0;
  logic        load_rx = 1'b0;
  logic        rx_drv = 1'b1;
  logic        lb = 1'b0;
  logic        rx_pin;
  logic        tx;
  logic [15:0] out_tx, out_rx;

  int checks = 0;
  int errors = 0;

  assign rx_pin = lb ? tx : rx_drv;

  hack_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_w), .load_tx(load_tx), .load_rx(load_rx),
    .rx(rx_pin), .tx(tx), .out_tx(out_tx), .out_rx(out_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns on the negedge that ends the stop bit.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic ack_rx();
    load_rx = 1'b1;
    in_w    = 16'h5A5A;
    @(negedge clk);
    load_rx = 1'b0;
    check("ack", out_rx, 16'h8000);
  endtask

  task automatic run_tx(input logic [7:0] b, input logic poke);
    logic exp_bit;
    in_w    = {8'h12, b};
    load_tx = 1'b1;
    @(negedge clk);
    load_tx = 1'b0;
    in_w    = '0;
    for (int k = 1; k <= 10 * CPB; k++) begin
      if (k <= CPB)            exp_bit = 1'b0;
      else if (k <= 9 * CPB)   exp_bit = b[(k - CPB - 1) / CPB];
      else                     exp_bit = 1'b1;
      check("tx_line", {15'b0, tx}, {15'b0, exp_bit});
      check("tx_busy", out_tx, 16'h8000);
      if (poke && k == 10) begin
        load_tx = 1'b1;
        in_w    = 16'h003C;
      end else begin
        load_tx = 1'b0;
      end
      @(negedge clk);
    end
    check("tx_done_busy", out_tx, 16'h0000);
    for (int k = 0; k < 20; k++) begin
      check("tx_after_idle", {15'b0, tx}, 16'h0001);
      check("tx_after_busy", out_tx, 16'h0000);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      check("rst_tx", {15'b0, tx}, 16'h0001);
      check("rst_out_tx", out_tx, 16'h0000);
      check("rst_out_rx", out_rx, 16'h8000);
      @(negedge clk);
    end

    run_tx(8'hA5, 1'b0);
    run_tx(8'hA5, 1'b1);

    send_rx(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    check("rx_3c", out_rx, 16'h003C);
    ack_rx();

    send_rx(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    check("rx_framing", out_rx, 16'h8000);

    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    check("rx_glitch", out_rx, 16'h8000);

    send_rx(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    check("rx_11", out_rx, 16'h0011);
    send_rx(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    check("rx_overwrite", out_rx, 16'h0022);
    ack_rx();

    send_rx(8'h33, 1'b1);
    load_rx = 1'b1;
    @(negedge clk);
    load_rx = 1'b0;
    check("rx_same_edge", out_rx, 16'h0033);
    repeat (4) @(negedge clk);
    ack_rx();

    lb      = 1'b1;
    @(negedge clk);
    in_w    = 16'h005A;
    load_tx = 1'b1;
    @(negedge clk);
    load_tx = 1'b0;
    for (int i = 0; i < 100 && out_rx[15]; i++) @(negedge clk);
    check("loopback", out_rx, 16'h005A);
    repeat (10) @(negedge clk);
    check("loopback_idle", out_tx, 16'h0000);
    lb = 1'b0;

    in_w    = 16'h0000;
    load_tx = 1'b1;
    @(negedge clk);
    load_tx = 1'b0;
    repeat (15) @(negedge clk);
    check("midframe_tx_low", {15'b0, tx}, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", {15'b0, tx}, 16'h0001);
    check("async_rst_out_tx", out_tx, 16'h0000);
    check("async_rst_out_rx", out_rx, 16'h8000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("post_rst_tx", {15'b0, tx}, 16'h0001);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_uart.md
Name: hack_uart

Overview:
- Memory-mapped UART peripheral occupying two I/O slots of the Hack memory map.
- Consumes the decoded per-slot load strobes and the CPU write data produced by the memory decoder.
- Returns two 16-bit status/data words to the decoder's per-slot read inputs.
- Provides 8N1 serial transmit and receive on the board pins. Both slots are readable by the Hack CPU as ordinary memory words.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200). Must be ≥ 4.

Ports:
- clk     input   1   system clock, all state on rising edge
- rst_n   input   1   asynchronous active-low reset
- in      input   16  CPU write data; only in[7:0] used
- load_tx input   1   write strobe for the TX slot, from the decoder
- load_rx input   1   write strobe for the RX slot (acknowledge), from the decoder
- rx      input   1   serial receive pin, asynchronous to clk
- tx      output  1   serial transmit pin, idles high
- out_tx  output  16  TX slot read value, routed to the decoder's per-slot input
- out_rx  output  16  RX slot read value, routed to the decoder's per-slot input

Behaviour:
- Reset (rst_n=0, asynchronous):
  - tx=1, out_tx=16'h0000, out_rx=16'h8000.
  - Both FSMs go to IDLE; all counters clear.
  - The rx synchroniser flops reset to 1.
  - Reset asserted mid-frame aborts the frame immediately; no partial byte is latched.
- out_tx = {busy,15'b0}. busy=1 whenever the TX FSM is not IDLE.
- TX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: when load_tx=1, latch in[7:0]. Next cycle is START with tx=0 and busy=1. Latency from strobe to tx falling edge is 1 clk.
  - START: hold for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - Total busy time is exactly 10*CLKS_PER_BIT cycles.
  - load_tx while busy is ignored; the in-flight byte is unaffected.
  - load_tx on the same edge the FSM returns to IDLE is also ignored. Software must poll for busy=0.
- rx path: 2-flop synchroniser, so sampling latency is 2 clk.
- RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronised low starts START.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample. If high (glitch), return to IDLE with nothing latched. If low, go to DATA.
  - DATA: sample at each bit centre (every CLKS_PER_BIT cycles), LSB first, 8 bits.
  - STOP: sample at the stop-bit centre.
    - High: out_rx={8'h00,byte} on the next clk, then IDLE.
    - Low (framing error): byte discarded, out_rx unchanged. The FSM waits for rx high before re-entering IDLE.
- out_rx[15]=1 means no data. Software polls until bit15=0, reads the byte, then writes any value to the RX slot.
- load_rx=1 sets out_rx=16'h8000 on the next clk.
- A new byte arriving while the previous one is unacknowledged overwrites it (no overrun flag).
- A byte completion and load_rx on the same edge: the new byte wins, so out_rx holds the new data.
- TX and RX operate fully independently. Loopback (tx tied to rx) must work.

Test Plan (CLKS_PER_BIT=4):
- Reset then idle: hold rst_n=0 for 3 clk, release → tx=1, out_tx=16'h0000, out_rx=16'h8000, stable for 50 clk.
- Transmit 0xA5: load_tx=1 with in=16'h12A5 for 1 clk → next clk tx=0 and out_tx=16'h8000. Line then carries 1,0,1,0,0,1,0,1 at 4 clk/bit (LSB first), then stop=1. out_tx returns to 16'h0000 exactly 40 clk after the strobe.
- Busy write ignored: during the 0xA5 frame pulse load_tx with in=16'h003C → waveform identical to the previous case, and no second frame follows.
- Receive 0x3C: drive a valid 8N1 frame on rx → out_rx=16'h003C within 3 clk of the stop-bit centre. Then load_rx=1 → out_rx=16'h8000 the next clk.
- Framing error and glitch:
  - rx frame 0x55 with stop bit 0 → out_rx stays 16'h8000.
  - 1-clk low pulse on rx → no frame detected, out_rx stays 16'h8000.
- Simultaneous/overwrite and reset:
  - Receive 0x11, then 0x22 unacknowledged → out_rx=16'h0022.
  - load_rx on the completion edge of 0x33 → out_rx=16'h0033.
  - rst_n pulsed low mid-TX-frame → tx=1 and out_tx=16'h0000 immediately (asynchronous).
